rx_pkt_ctrl: RTL and testbench
==============================

RX_PKT_CTRL -- requirements
Module: rx_pkt_ctrl

Interface
REQ-001 Parameter SYNC_PATTERN, default 8'h80, expected sync byte.
REQ-002 Parameter MAX_BYTES, default 64, maximum payload bytes after PID (range 1..1023).
REQ-003 Parameter PID_CHECK, default 1, enables PID nibble-complement check (0 = accept any PID).
REQ-004 Parameter EOP_HOLD_BITS, default 2, shift_enable strobes counted after EOP before release (range 1..7).
REQ-005 Derived CNT_W = $clog2(MAX_BYTES+1).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 d_edge  in  1  line transition detected.
REQ-009 eop  in  1  end-of-packet (SE0) detected.
REQ-010 shift_enable  in  1  one-cycle bit-sample strobe.
REQ-011 byte_received  in  1  one-cycle pulse, rcv_data holds a complete byte.
REQ-012 rcv_data  in  8  received byte, LSB first on the line.
REQ-013 bit_count  in  4  bits shifted into the current byte.
REQ-014 rcving  out  1  packet reception in progress.
REQ-015 w_enable  out  1  one-cycle write strobe to the RX FIFO.
REQ-016 r_error  out  1  packet error flag.
REQ-017 err_code  out  2  00 none, 01 bad sync, 10 bad PID, 11 framing/overflow.
REQ-018 PID  out  4  last accepted PID.
REQ-019 byte_cnt  out  CNT_W  payload bytes written in the current packet.
REQ-020 pkt_done  out  1  one-cycle pulse on error-free packet completion.

Function
REQ-021 All outputs SHALL be registered; every response appears the cycle after its causing input.
REQ-022 States SHALL be IDLE, SYNC_WAIT, PID_WAIT, DATA_WAIT, EOP_CHK, EOP_HOLD, ERR_WAIT_EOP, ERR_HOLD, ERR_IDLE.
REQ-023 IDLE/ERR_IDLE + d_edge -> SYNC_WAIT; rcving=1, r_error=0, err_code=00, byte_cnt=0, PID=4'hF.
REQ-024 SYNC_WAIT + byte_received: rcv_data==SYNC_PATTERN -> PID_WAIT; else -> ERR_WAIT_EOP, r_error=1, err_code=01.
REQ-025 PID_WAIT + byte_received: PID_CHECK=1 and rcv_data[7:4] != ~rcv_data[3:0] -> ERR_WAIT_EOP, err_code=10, no w_enable; else PID=rcv_data[3:0], w_enable pulse, -> DATA_WAIT.
REQ-026 PID_WAIT + eop&&shift_enable -> ERR_HOLD, r_error=1, err_code=11.
REQ-027 DATA_WAIT + byte_received: byte_cnt<MAX_BYTES -> w_enable pulse, byte_cnt+1; byte_cnt==MAX_BYTES -> ERR_WAIT_EOP, err_code=11, no w_enable, byte_cnt holds.
REQ-028 DATA_WAIT + eop&&shift_enable -> EOP_CHK; eop has priority over a simultaneous byte_received (byte dropped).
REQ-029 EOP_CHK (one cycle): bit_count==1 -> EOP_HOLD; else -> ERR_HOLD, r_error=1, err_code=11.
REQ-030 EOP_HOLD/ERR_HOLD SHALL count EOP_HOLD_BITS shift_enable strobes (3-bit counter, cleared on entry), then exit.
REQ-031 EOP_HOLD exit -> IDLE; rcving=0 and pkt_done=1 in the same cycle, pkt_done for one cycle only.
REQ-032 ERR_WAIT_EOP: r_error=1, rcving=1, ignores byte_received; eop&&shift_enable -> ERR_HOLD.
REQ-033 ERR_HOLD exit -> ERR_IDLE; rcving=0; r_error and err_code held until next d_edge.
REQ-034 d_edge SHALL be ignored in all states except IDLE and ERR_IDLE.
REQ-035 w_enable SHALL never assert in any error state or in the cycle r_error rises.
REQ-036 err_code SHALL record only the first error of a packet.

Reset
REQ-037 rst high SHALL immediately force IDLE, rcving=0, w_enable=0, r_error=0, err_code=00, PID=4'hF, byte_cnt=0, pkt_done=0, hold counter=0.
REQ-038 Reset mid-packet SHALL abort without pkt_done or w_enable; first d_edge after rst falls starts a new packet.

Verification
REQ-039 Sync 8'h80, PID 8'hD2, bytes 8'h11,8'h22, eop with bit_count=1 -> 3 w_enable pulses, PID=4'h2, byte_cnt=2, pkt_done once after 2 strobes, r_error=0.
REQ-040 Sync 8'h81 -> r_error=1, err_code=01 next cycle, no w_enable; after eop+2 strobes rcving=0, r_error stays 1 until d_edge.
REQ-041 PID 8'hC2 with PID_CHECK=1 -> err_code=10, no w_enable; PID_CHECK=0 -> accepted, PID=4'h2.
REQ-042 MAX_BYTES=4, six payload bytes -> 4 data w_enable pulses, 5th byte sets err_code=11, byte_cnt=4, no pkt_done.
REQ-043 eop with bit_count=5, and eop coincident with byte_received -> err_code=11 / byte dropped, no extra w_enable.
REQ-044 rst asserted in DATA_WAIT after 3 bytes -> all outputs reset same cycle, no pkt_done; next packet completes normally.

Source files
------------

// File: rtl/rx_pkt_ctrl_if.sv
// Receive-side handshake bundle between the bit-level USB receiver
// (master: decoded line events and bytes) and the packet controller (slave).
interface rx_pkt_ctrl_if #(
  parameter int MAX_BYTES = 64
);
  localparam int CNT_W = $clog2(MAX_BYTES + 1);

  logic             d_edge;
  logic             eop;
  logic             shift_enable;
  logic             byte_received;
  logic [7:0]       rcv_data;
  logic [3:0]       bit_count;
  logic             rcving;
  logic             w_enable;
  logic             r_error;
  logic [1:0]       err_code;
  logic [3:0]       PID;
  logic [CNT_W-1:0] byte_cnt;
  logic             pkt_done;

  modport master (
    output d_edge, eop, shift_enable, byte_received, rcv_data, bit_count,
    input  rcving, w_enable, r_error, err_code, PID, byte_cnt, pkt_done
  );

  modport slave (
    input  d_edge, eop, shift_enable, byte_received, rcv_data, bit_count,
    output rcving, w_enable, r_error, err_code, PID, byte_cnt, pkt_done
  );
endinterface

// File: rtl/rx_pkt_ctrl.sv
// USB receive packet controller: tracks sync / PID / payload / EOP framing,
// strobes accepted bytes into the RX FIFO and reports the first error of a
// packet. Every output is a register loaded from the next-state logic, so each
// response appears one cycle after its cause.
module rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_PATTERN  = 8'h80,
  parameter int         MAX_BYTES     = 64,
  parameter int         PID_CHECK     = 1,
  parameter int         EOP_HOLD_BITS = 2
) (
  input logic          clk,
  input logic          rst,
  rx_pkt_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BYTES);
  localparam logic [2:0]       HOLD_LAST = 3'(EOP_HOLD_BITS - 1);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    SYNC_WAIT    = 4'd1,
    PID_WAIT     = 4'd2,
    DATA_WAIT    = 4'd3,
    EOP_CHK      = 4'd4,
    EOP_HOLD     = 4'd5,
    ERR_WAIT_EOP = 4'd6,
    ERR_HOLD     = 4'd7,
    ERR_IDLE     = 4'd8
  } state_t;

  state_t           state, next_state;
  logic             rcving, next_rcving;
  logic             w_enable, next_w_enable;
  logic             r_error, next_r_error;
  logic [1:0]       err_code, next_err_code;
  logic [3:0]       pid, next_pid;
  logic [CNT_W-1:0] byte_cnt, next_byte_cnt;
  logic             pkt_done, next_pkt_done;
  logic [2:0]       hold_cnt, next_hold_cnt;
  logic             eop_strobe;
  logic             pid_ok;

  assign bus.rcving   = rcving;
  assign bus.w_enable = w_enable;
  assign bus.r_error  = r_error;
  assign bus.err_code = err_code;
  assign bus.PID      = pid;
  assign bus.byte_cnt = byte_cnt;
  assign bus.pkt_done = pkt_done;

  // State and output registers; reset drops any packet in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rcving   <= 1'b0;
      w_enable <= 1'b0;
      r_error  <= 1'b0;
      err_code <= 2'b00;
      pid      <= 4'hF;
      byte_cnt <= '0;
      pkt_done <= 1'b0;
      hold_cnt <= 3'd0;
    end else begin
      state    <= next_state;
      rcving   <= next_rcving;
      w_enable <= next_w_enable;
      r_error  <= next_r_error;
      err_code <= next_err_code;
      pid      <= next_pid;
      byte_cnt <= next_byte_cnt;
      pkt_done <= next_pkt_done;
      hold_cnt <= next_hold_cnt;
    end
  end

  // Next-state and next-output decode; errors are only raised from
  // non-error states, so err_code always keeps the first error.
  always_comb begin
    next_state    = state;
    next_rcving   = rcving;
    next_w_enable = 1'b0;
    next_r_error  = r_error;
    next_err_code = err_code;
    next_pid      = pid;
    next_byte_cnt = byte_cnt;
    next_pkt_done = 1'b0;
    next_hold_cnt = hold_cnt;
    eop_strobe    = bus.eop && bus.shift_enable;
    pid_ok        = (PID_CHECK == 0) || (bus.rcv_data[7:4] == ~bus.rcv_data[3:0]);

    case (state)
      IDLE, ERR_IDLE: begin
        if (bus.d_edge) begin
          next_state    = SYNC_WAIT;
          next_rcving   = 1'b1;
          next_r_error  = 1'b0;
          next_err_code = 2'b00;
          next_byte_cnt = '0;
          next_pid      = 4'hF;
        end else begin
          next_state = state;
        end
      end
      SYNC_WAIT: begin
        // An EOP before any sync byte is a truncated packet.
        if (eop_strobe) begin
          next_state    = ERR_HOLD;
          next_r_error  = 1'b1;
          next_err_code = 2'b11;
        end else if (bus.byte_received) begin
          if (bus.rcv_data == SYNC_PATTERN) begin
            next_state = PID_WAIT;
          end else begin
            next_state    = ERR_WAIT_EOP;
            next_r_error  = 1'b1;
            next_err_code = 2'b01;
          end
        end else begin
          next_state = SYNC_WAIT;
        end
      end
      PID_WAIT: begin
        if (eop_strobe) begin
          next_state    = ERR_HOLD;
          next_r_error  = 1'b1;
          next_err_code = 2'b11;
        end else if (bus.byte_received) begin
          if (pid_ok) begin
            next_state    = DATA_WAIT;
            next_pid      = bus.rcv_data[3:0];
            next_w_enable = 1'b1;
          end else begin
            next_state    = ERR_WAIT_EOP;
            next_r_error  = 1'b1;
            next_err_code = 2'b10;
          end
        end else begin
          next_state = PID_WAIT;
        end
      end
      DATA_WAIT: begin
        // EOP wins over a coincident byte; that partial byte is dropped.
        if (eop_strobe) begin
          next_state = EOP_CHK;
        end else if (bus.byte_received) begin
          if (byte_cnt < MAX_CNT) begin
            next_w_enable = 1'b1;
            next_byte_cnt = byte_cnt + 1'b1;
          end else begin
            next_state    = ERR_WAIT_EOP;
            next_r_error  = 1'b1;
            next_err_code = 2'b11;
          end
        end else begin
          next_state = DATA_WAIT;
        end
      end
      EOP_CHK: begin
        // A clean EOP leaves exactly one bit shifted into the next byte.
        if (bus.bit_count == 4'd1) begin
          next_state = EOP_HOLD;
        end else begin
          next_state    = ERR_HOLD;
          next_r_error  = 1'b1;
          next_err_code = 2'b11;
        end
      end
      EOP_HOLD: begin
        if (bus.shift_enable && (hold_cnt == HOLD_LAST)) begin
          next_state    = IDLE;
          next_rcving   = 1'b0;
          next_pkt_done = 1'b1;
        end else if (bus.shift_enable) begin
          next_hold_cnt = hold_cnt + 3'd1;
        end else begin
          next_hold_cnt = hold_cnt;
        end
      end
      ERR_WAIT_EOP: begin
        if (eop_strobe) begin
          next_state = ERR_HOLD;
        end else begin
          next_state = ERR_WAIT_EOP;
        end
      end
      ERR_HOLD: begin
        if (bus.shift_enable && (hold_cnt == HOLD_LAST)) begin
          next_state  = ERR_IDLE;
          next_rcving = 1'b0;
        end else if (bus.shift_enable) begin
          next_hold_cnt = hold_cnt + 3'd1;
        end else begin
          next_hold_cnt = hold_cnt;
        end
      end
      default: begin
        next_state  = IDLE;
        next_rcving = 1'b0;
      end
    endcase

    // The hold counter starts from zero in whichever state is entered next.
    if (next_state != state) begin
      next_hold_cnt = 3'd0;
    end else begin
      next_hold_cnt = next_hold_cnt;
    end
  end
endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Bench for rx_pkt_ctrl: three configurations (default, MAX_BYTES=4,
// PID_CHECK=0) receive the same packet stream; each packet's outcome is
// predicted from the packet contents alone and compared per configuration.
module tb_rx_pkt_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_edge = 1'b0, eop = 1'b0, shift_enable = 1'b0, byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic [3:0] bit_count = 4'd0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rx_pkt_ctrl_if #(.MAX_BYTES(64)) if_a ();
  rx_pkt_ctrl_if #(.MAX_BYTES(4))  if_b ();
  rx_pkt_ctrl_if #(.MAX_BYTES(64)) if_c ();

  rx_pkt_ctrl #(.MAX_BYTES(64), .PID_CHECK(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  rx_pkt_ctrl #(.MAX_BYTES(4),  .PID_CHECK(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  rx_pkt_ctrl #(.MAX_BYTES(64), .PID_CHECK(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.d_edge = d_edge, if_a.eop = eop, if_a.shift_enable = shift_enable,
         if_a.byte_received = byte_received, if_a.rcv_data = rcv_data, if_a.bit_count = bit_count;
  assign if_b.d_edge = d_edge, if_b.eop = eop, if_b.shift_enable = shift_enable,
         if_b.byte_received = byte_received, if_b.rcv_data = rcv_data, if_b.bit_count = bit_count;
  assign if_c.d_edge = d_edge, if_c.eop = eop, if_c.shift_enable = shift_enable,
         if_c.byte_received = byte_received, if_c.rcv_data = rcv_data, if_c.bit_count = bit_count;

  logic       rcv_o[3], wen_o[3], err_o[3], done_o[3];
  logic [1:0] code_o[3];
  logic [3:0] pid_o[3];
  logic [9:0] cnt_o[3];

  assign rcv_o[0] = if_a.rcving, rcv_o[1] = if_b.rcving, rcv_o[2] = if_c.rcving;
  assign wen_o[0] = if_a.w_enable, wen_o[1] = if_b.w_enable, wen_o[2] = if_c.w_enable;
  assign err_o[0] = if_a.r_error, err_o[1] = if_b.r_error, err_o[2] = if_c.r_error;
  assign done_o[0] = if_a.pkt_done, done_o[1] = if_b.pkt_done, done_o[2] = if_c.pkt_done;
  assign code_o[0] = if_a.err_code, code_o[1] = if_b.err_code, code_o[2] = if_c.err_code;
  assign pid_o[0] = if_a.PID, pid_o[1] = if_b.PID, pid_o[2] = if_c.PID;
  assign cnt_o[0] = 10'(if_a.byte_cnt), cnt_o[1] = 10'(if_b.byte_cnt), cnt_o[2] = 10'(if_c.byte_cnt);

  int wen_cnt[3]  = '{0, 0, 0};
  int done_cnt[3] = '{0, 0, 0};

  // Count FIFO write strobes and completion pulses of every instance.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wen_o[k])  wen_cnt[k]  <= wen_cnt[k] + 1;
      if (done_o[k]) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  typedef struct {
    int         wen;
    int         done;
    logic       err;
    logic [1:0] code;
    logic [3:0] pid;
    int         cnt;
  } exp_t;

  int cfg_max[3]  = '{64, 4, 64};
  bit cfg_pchk[3] = '{1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet-level outcome: first error wins, payload capped at the byte limit.
  function automatic exp_t model(input logic [7:0] sync, input logic [7:0] pid, input int n,
                                 input logic [3:0] bc, input int maxb, input bit pchk);
    exp_t e;
    logic [3:0] hi, lo;
    e = '{wen: 0, done: 0, err: 1'b0, code: 2'b00, pid: 4'hF, cnt: 0};
    hi = pid[7:4];
    lo = pid[3:0];
    if (sync != 8'h80) begin
      e.err = 1'b1; e.code = 2'b01;
    end else if (pchk && (hi != ~lo)) begin
      e.err = 1'b1; e.code = 2'b10;
    end else begin
      e.pid = lo;
      if (n > maxb) begin
        e.wen = 1 + maxb; e.cnt = maxb; e.err = 1'b1; e.code = 2'b11;
      end else begin
        e.wen = 1 + n; e.cnt = n;
        if (bc != 4'd1) begin
          e.err = 1'b1; e.code = 2'b11;
        end else begin
          e.done = 1;
        end
      end
    end
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_received = 1'b1;
    rcv_data = b;
    @(negedge clk);
    byte_received = 1'b0;
  endtask

  task automatic hold_strobe();
    @(negedge clk);
    shift_enable = 1'b1;
    @(negedge clk);
    shift_enable = 1'b0;
  endtask

  task automatic start_pkt();
    @(negedge clk);
    d_edge = 1'b1;
    @(negedge clk);
    d_edge = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rcving_start[%0d]", k), 32'(rcv_o[k]), 32'd1);
      chk($sformatf("err_clear[%0d]", k), 32'({err_o[k], code_o[k]}), 32'd0);
    end
  endtask

  task automatic send_pkt(input logic [7:0] sync, input logic [7:0] pid, input int n,
                          input logic [3:0] bc, input bit with_byte);
    exp_t e[3];
    int   w0[3], d0[3];
    for (int k = 0; k < 3; k++) begin
      e[k]  = model(sync, pid, n, bc, cfg_max[k], cfg_pchk[k]);
      w0[k] = wen_cnt[k];
      d0[k] = done_cnt[k];
    end
    start_pkt();
    idle(2);
    send_byte(sync);
    if (sync != 8'h80) begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("sync_err[%0d]", k), 32'({err_o[k], code_o[k]}), 32'h5);
    end
    idle(1);
    send_byte(pid);
    for (int k = 0; k < 3; k++) begin
      if (e[k].code == 2'b10)
        chk($sformatf("pid_err[%0d]", k), 32'({err_o[k], code_o[k]}), 32'h6);
    end
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom));
      idle($urandom_range(0, 2));
    end
    bit_count = bc;
    @(negedge clk);
    eop = 1'b1;
    shift_enable = 1'b1;
    if (with_byte) begin
      byte_received = 1'b1;
      rcv_data = 8'($urandom);
    end
    @(negedge clk);
    eop = 1'b0;
    shift_enable = 1'b0;
    byte_received = 1'b0;
    idle(3);
    hold_strobe();
    for (int k = 0; k < 3; k++)
      chk($sformatf("hold_mid[%0d]", k), 32'(rcv_o[k]), 32'd1);
    idle(3);
    hold_strobe();
    for (int k = 0; k < 3; k++)
      chk($sformatf("hold_end[%0d]", k), 32'(rcv_o[k]), 32'd0);
    idle(2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wen_pulses[%0d]", k), 32'(wen_cnt[k] - w0[k]), 32'(e[k].wen));
      chk($sformatf("pkt_done[%0d]", k), 32'(done_cnt[k] - d0[k]), 32'(e[k].done));
      chk($sformatf("r_error[%0d]", k), 32'(err_o[k]), 32'(e[k].err));
      chk($sformatf("err_code[%0d]", k), 32'(code_o[k]), 32'(e[k].code));
      chk($sformatf("pid[%0d]", k), 32'(pid_o[k]), 32'(e[k].pid));
      chk($sformatf("byte_cnt[%0d]", k), 32'(cnt_o[k]), 32'(e[k].cnt));
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_rcving[%0d]", tag, k), 32'(rcv_o[k]), 32'd0);
      chk($sformatf("%s_wen[%0d]", tag, k), 32'(wen_o[k]), 32'd0);
      chk($sformatf("%s_err[%0d]", tag, k), 32'({err_o[k], code_o[k]}), 32'd0);
      chk($sformatf("%s_pid[%0d]", tag, k), 32'(pid_o[k]), 32'hF);
      chk($sformatf("%s_cnt[%0d]", tag, k), 32'(cnt_o[k]), 32'd0);
      chk($sformatf("%s_done[%0d]", tag, k), 32'(done_o[k]), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] sync, pid;
    logic [3:0] lo, bc;
    int         d0[3];

    idle(3);
    check_reset_state("por");
    rst = 1'b0;
    idle(2);

    send_pkt(8'h80, 8'hD2, 2, 4'd1, 1'b0);   // clean packet
    send_pkt(8'h81, 8'hD2, 2, 4'd1, 1'b0);   // bad sync
    send_pkt(8'h80, 8'hC2, 2, 4'd1, 1'b0);   // bad PID unless check disabled
    send_pkt(8'h80, 8'hD2, 6, 4'd1, 1'b0);   // overflow on the 4-byte instance
    send_pkt(8'h80, 8'hD2, 2, 4'd5, 1'b0);   // EOP mid-byte
    send_pkt(8'h80, 8'hD2, 2, 4'd1, 1'b1);   // byte coincident with EOP dropped
    send_pkt(8'h80, 8'hD2, 4, 4'd1, 1'b1);   // exactly at the byte limit

    // Reset in the middle of the payload.
    for (int k = 0; k < 3; k++) d0[k] = done_cnt[k];
    bit_count = 4'd1;
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hD2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    #2 rst = 1'b1;
    #1 check_reset_state("mid_rst");
    idle(2);
    rst = 1'b0;
    idle(2);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rst_no_done[%0d]", k), 32'(done_cnt[k] - d0[k]), 32'd0);
    send_pkt(8'h80, 8'hA5, 3, 4'd1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      sync = 8'h80;
      if ($urandom_range(0, 7) == 0) begin
        sync = 8'($urandom);
        if (sync == 8'h80) sync = 8'h81;
      end
      lo = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       pid = 8'($urandom);
        1:       pid = 8'hC2;
        default: pid = {~lo, lo};
      endcase
      bc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'd1;
      send_pkt(sync, pid, $urandom_range(0, 7), bc, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
